// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver state encoding and a sizing helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {
    S_WF_IDLE = 3'd0,
    S_IDLE    = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
    S_PARITY  = 3'd4,
    S_STOP    = 3'd5
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises sdin and majority-votes the samples around mid-bit
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sdin,
  input  logic strobe,
  output logic s,
  output logic bit_val
);
  logic [SYNC_STAGES-1:0] sync;
  logic [1:0] taps;
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '1;
      taps <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sdin};
      if (strobe) taps <= {taps[0], s};
    end
  assign s = sync[SYNC_STAGES-1];
  // taps hold the two earlier samples; the live s is the third vote
  assign bit_val = (taps[1] & taps[0]) | (taps[1] & s) | (taps[0] & s);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority voting and a valid/ready holding register
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 220,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sdin,
  input  logic                 data_ready,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW = clog2(CLKS_PER_BIT);
  localparam int CW = clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE = TW'(HALF - 1);
  localparam logic [TW-1:0] T_MID = TW'(HALF);
  localparam logic [TW-1:0] T_COMMIT = TW'(HALF + 1);
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] sr;
  logic s, bit_val, par_bad, stop_bad;
  logic commit, bit_end, last_cnt, stop_eval, frame_bad, good, load;
  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk     (clk),
    .reset   (reset),
    .sdin    (sdin),
    .strobe  (timer == T_PRE || timer == T_MID),
    .s       (s),
    .bit_val (bit_val)
  );
  assign busy = state inside {S_START, S_DATA, S_PARITY, S_STOP};
  always_comb begin
    commit = busy && timer == T_COMMIT;
    bit_end = timer == T_LAST;
    last_cnt = state == S_DATA ? cnt == CW'(DATA_BITS - 1) : cnt == CW'(STOP_BITS - 1);
    stop_eval = state == S_STOP && commit && last_cnt;
    frame_bad = stop_bad || !bit_val;
    good = stop_eval && !frame_bad && !par_bad;
    load = good && (!data_valid || data_ready);
    state_n = state;
    case (state)
      S_WF_IDLE: state_n = s ? S_IDLE : S_WF_IDLE;
      S_IDLE:    state_n = s ? S_IDLE : S_START;
      S_START:   state_n = commit && bit_val ? S_IDLE : bit_end ? S_DATA : S_START;
      S_DATA:    state_n = bit_end && last_cnt ? (PARITY != PAR_NONE ? S_PARITY : S_STOP) : S_DATA;
      S_PARITY:  state_n = bit_end ? S_STOP : S_PARITY;
      S_STOP:    state_n = stop_eval ? (frame_bad ? S_WF_IDLE : S_IDLE) : S_STOP;
      default:   state_n = S_WF_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_WF_IDLE;
      timer <= '0;
      cnt <= '0;
      sr <= '0;
      par_bad <= 1'b0;
      stop_bad <= 1'b0;
      data_valid <= 1'b0;
      data <= '0;
      parity_error <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state <= state_n;
      timer <= (!busy || bit_end) ? '0 : timer + 1'b1;
      // bit counter restarts on every state change, so it serves data and stop bits alike
      cnt <= state_n != state ? '0 : bit_end ? cnt + 1'b1 : cnt;
      if (state == S_IDLE) begin
        par_bad <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (commit && state == S_DATA) sr <= {bit_val, sr[DATA_BITS-1:1]};
      if (commit && state == S_PARITY) par_bad <= (^sr ^ bit_val) != (PARITY == PAR_ODD);
      if (commit && state == S_STOP) stop_bad <= stop_bad | !bit_val;
      parity_error <= stop_eval && !frame_bad && par_bad;
      framing_error <= stop_eval && frame_bad;
      overrun_error <= good && !load;
      if (load) data <= sr;
      data_valid <= load || (data_valid && !data_ready);
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: four receiver configurations driven by directed and random frames against a frame-level model
module tb_uart_rx_param;
  import uart_pkg::*;
  localparam int N = 4;
  localparam int SYNC = 2;
  int cpb [N] = '{16, 16, 16, 20};
  int db [N] = '{8, 7, 8, 9};
  int par [N] = '{PAR_NONE, PAR_EVEN, PAR_NONE, PAR_ODD};
  int nstop [N] = '{1, 1, 2, 1};
  logic clk = 1'b0;
  logic rst [N];
  logic sdin [N];
  logic rdy [N];
  logic dv [N];
  logic pe [N];
  logic fe [N];
  logic oe [N];
  logic bsy [N];
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [8:0] d3;
  logic [8:0] dat [N];
  always #5 clk = ~clk;
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_a (
    .clk(clk), .reset(rst[0]), .sdin(sdin[0]), .data_ready(rdy[0]), .data_valid(dv[0]), .data(d0),
    .parity_error(pe[0]), .framing_error(fe[0]), .overrun_error(oe[0]), .busy(bsy[0]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_b (
    .clk(clk), .reset(rst[1]), .sdin(sdin[1]), .data_ready(rdy[1]), .data_valid(dv[1]), .data(d1),
    .parity_error(pe[1]), .framing_error(fe[1]), .overrun_error(oe[1]), .busy(bsy[1]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(SYNC)) u_c (
    .clk(clk), .reset(rst[2]), .sdin(sdin[2]), .data_ready(rdy[2]), .data_valid(dv[2]), .data(d2),
    .parity_error(pe[2]), .framing_error(fe[2]), .overrun_error(oe[2]), .busy(bsy[2]));
  uart_rx_param #(.CLKS_PER_BIT(20), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_d (
    .clk(clk), .reset(rst[3]), .sdin(sdin[3]), .data_ready(rdy[3]), .data_valid(dv[3]), .data(d3),
    .parity_error(pe[3]), .framing_error(fe[3]), .overrun_error(oe[3]), .busy(bsy[3]));
  always_comb begin
    dat[0] = {1'b0, d0};
    dat[1] = {2'b0, d1};
    dat[2] = {1'b0, d2};
    dat[3] = d3;
  end
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int unstable = 0;
  int n_dv [N] = '{default: 0};
  int n_pe [N] = '{default: 0};
  int n_fe [N] = '{default: 0};
  int n_oe [N] = '{default: 0};
  int rise_cyc [N] = '{default: 0};
  logic [8:0] rise_dat [N] = '{default: '0};
  logic prev_dv [N] = '{default: 1'b0};
  logic [8:0] prev_dat [N] = '{default: '0};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int i = 0; i < N; i++) begin
      if (dv[i] && !prev_dv[i]) begin
        n_dv[i]++;
        rise_cyc[i] = cyc;
        rise_dat[i] = dat[i];
      end
      if (dv[i] && prev_dv[i] && dat[i] != prev_dat[i]) unstable++;
      n_pe[i] += int'(pe[i]);
      n_fe[i] += int'(fe[i]);
      n_oe[i] += int'(oe[i]);
      prev_dv[i] = dv[i];
      prev_dat[i] = dat[i];
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] mask(input int i, input logic [8:0] w);
    return w & 9'((1 << db[i]) - 1);
  endfunction
  function automatic logic par_bit(input int i, input logic [8:0] w);
    return (^mask(i, w)) ^ (par[i] == PAR_ODD);
  endfunction
  // pin-to-s latency, T0 cycle, committed mid-point of the last stop bit, then one register stage
  function automatic int latency(input int i);
    return SYNC + 3 + (db[i] + (par[i] != PAR_NONE ? 1 : 0) + nstop[i]) * cpb[i] + cpb[i] / 2;
  endfunction
  task automatic hold(input int i, input logic v, input int n);
    sdin[i] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input int i, input logic [8:0] w, input logic flip, input int bad_stop, output int start);
    start = cyc;
    hold(i, 1'b0, cpb[i]);
    for (int b = 0; b < db[i]; b++) hold(i, w[b], cpb[i]);
    if (par[i] != PAR_NONE) hold(i, par_bit(i, w) ^ flip, cpb[i]);
    for (int k = 0; k < nstop[i]; k++) hold(i, k != bad_stop, cpb[i]);
  endtask
  task automatic run(input int i, input logic [8:0] w, input logic flip, input int bad_stop, input string tag);
    int dv0, pe0, fe0, oe0, st;
    logic exp_fe, exp_pe, ok;
    dv0 = n_dv[i];
    pe0 = n_pe[i];
    fe0 = n_fe[i];
    oe0 = n_oe[i];
    send_frame(i, w, flip, bad_stop, st);
    hold(i, 1'b1, 2 * cpb[i]);
    exp_fe = bad_stop >= 0;
    exp_pe = !exp_fe && par[i] != PAR_NONE && flip;
    ok = !exp_fe && !exp_pe;
    check({tag, ".dv"}, n_dv[i] - dv0, 32'(ok));
    check({tag, ".pe"}, n_pe[i] - pe0, 32'(exp_pe));
    check({tag, ".fe"}, n_fe[i] - fe0, 32'(exp_fe));
    check({tag, ".oe"}, n_oe[i] - oe0, 0);
    if (ok) begin
      check({tag, ".data"}, rise_dat[i], mask(i, w));
      check({tag, ".lat"}, rise_cyc[i] - st, latency(i));
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int st, dv0, pe0, fe0, oe0, kind;
    logic [8:0] w;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      sdin[i] = 1'b1;
      rdy[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("reset.outs%0d", i), {dv[i], pe[i], fe[i], oe[i], bsy[i], dat[i]}, 0);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    run(0, 9'h0A5, 1'b0, -1, "s1");
    run(1, 9'h035, 1'b0, -1, "s2.good");
    run(1, 9'h035, 1'b1, -1, "s2.badpar");
    dv0 = n_dv[0]; pe0 = n_pe[0]; fe0 = n_fe[0]; oe0 = n_oe[0];
    hold(0, 1'b0, 5);
    check("s3.busy_hi", bsy[0], 1);
    hold(0, 1'b1, 3 * cpb[0]);
    check("s3.busy_lo", bsy[0], 0);
    check("s3.quiet", (n_dv[0] - dv0) + (n_pe[0] - pe0) + (n_fe[0] - fe0) + (n_oe[0] - oe0), 0);
    run(0, 9'h03C, 1'b0, -1, "s3.next");
    dv0 = n_dv[2]; pe0 = n_pe[2]; fe0 = n_fe[2];
    send_frame(2, 9'h081, 1'b0, 1, st);
    hold(2, 1'b0, 40);
    hold(2, 1'b1, 2 * cpb[2]);
    check("s4.fe", n_fe[2] - fe0, 1);
    check("s4.pe", n_pe[2] - pe0, 0);
    check("s4.dv", n_dv[2] - dv0, 0);
    run(2, 9'h042, 1'b0, -1, "s4.next");
    rdy[0] = 1'b0;
    dv0 = n_dv[0]; oe0 = n_oe[0];
    send_frame(0, 9'h011, 1'b0, -1, st);
    send_frame(0, 9'h022, 1'b0, -1, st);
    hold(0, 1'b1, cpb[0]);
    check("s5.rises", n_dv[0] - dv0, 1);
    check("s5.oe", n_oe[0] - oe0, 1);
    check("s5.held_dv", dv[0], 1);
    check("s5.held_data", dat[0], 9'h011);
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("s5.dv_fall", dv[0], 0);
    for (int i = 0; i < N; i++)
      for (int f = 0; f < 8; f++) begin
        w = 9'($urandom);
        kind = int'($urandom_range(0, 3));
        run(i, w, kind == 2, kind == 3 ? int'($urandom_range(0, nstop[i] - 1)) : -1, $sformatf("rnd%0d.%0d", i, f));
      end
    run(3, 9'h0F0, 1'b0, -1, "s6.pre");
    dv0 = n_dv[3]; pe0 = n_pe[3]; fe0 = n_fe[3]; oe0 = n_oe[3];
    hold(3, 1'b0, cpb[3]);
    for (int b = 0; b < 4; b++) hold(3, 1'b1, cpb[3]);
    hold(3, 1'b1, cpb[3] / 2);
    rst[3] = 1'b1;
    @(posedge clk);
    #1;
    rst[3] = 1'b0;
    check("s6.reset_outs", {dv[3], pe[3], fe[3], oe[3], bsy[3], dat[3]}, 0);
    hold(3, 1'b1, 3 * cpb[3]);
    check("s6.quiet", (n_dv[3] - dv0) + (n_pe[3] - pe0) + (n_fe[3] - fe0) + (n_oe[3] - oe0), 0);
    run(3, 9'h155, 1'b0, -1, "s6.next");
    check("data_stable", unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Supports configurable data width, parity mode and stop-bit count. Adds an input synchroniser, 3-sample majority voting, and false-start rejection. Received bytes are presented through a valid/ready holding register with parity, framing and overrun flags. Sits between the board RX pin and the command parser on the PC-to-drone link.

Parameters:
CLKS_PER_BIT, 220, clk cycles per bit; minimum 8; HALF = CLKS_PER_BIT/2 (integer divide).
DATA_BITS, 8, data bits per frame; legal range 5..9; LSb first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, synchroniser flops on sdin; minimum 2.

Ports:
clk  in  1  system clock; the single clock for the block.
reset  in  1  synchronous, active-high reset.
sdin  in  1  asynchronous serial line; idles high.
data_ready  in  1  consumer accepts data when high.
data_valid  out  1  holding register contains an unread frame.
data  out  DATA_BITS  received word; bit 0 is the first received data bit.
parity_error  out  1  one-cycle pulse; frame had bad parity and is discarded.
framing_error  out  1  one-cycle pulse; a stop bit sampled low and the frame is discarded.
overrun_error  out  1  one-cycle pulse; a good frame completed while data_valid=1 and is dropped.
busy  out  1  high in S_START through S_STOP.

Behaviour:
- Reset: all outputs 0; data = 0; state S_WF_IDLE; timer, bit counter and shift register all 0. Reset applied mid-frame aborts the frame and produces no flags.
- sdin passes through SYNC_STAGES flops to give s. All decisions below use s. Latency from the pin to s is SYNC_STAGES cycles.
- Majority vote: at a sample point (timer == HALF), bit value = majority(s at timer HALF-1, HALF, HALF+1). The decision is committed at timer == HALF+1.
- Timer counts 0..CLKS_PER_BIT-1 within each bit, then wraps to 0 and advances the bit.
- State machine:
  - S_WF_IDLE: wait for s=1, then go to S_IDLE. This state is entered after reset and after a framing error, so a break condition yields only one error.
  - S_IDLE: on s=0, clear the timer and go to S_START. That cycle is T0.
  - S_START: majority sample at mid-bit. If the result is 1 (glitch), return to S_IDLE with no flags. If 0, at the end of the bit go to S_DATA.
  - S_DATA: sample DATA_BITS bits into the shift register, LSb first. After the last bit go to S_PARITY if PARITY != 0, else S_STOP.
  - S_PARITY: sample the parity bit. Check: for even parity, XOR(data, p) = 0; for odd parity, XOR(data, p) = 1. The result is held until stop-bit evaluation.
  - S_STOP: sample each stop bit. Evaluation happens at the committed mid-point of the last stop bit. The block does not wait for the bit to end, so back-to-back frames are captured.
- Stop-bit evaluation, priority order:
  - Any stop bit sampled 0: framing_error pulse, frame discarded, go to S_WF_IDLE. parity_error is not also asserted.
  - Otherwise parity bad: parity_error pulse, frame discarded, go to S_IDLE.
  - Otherwise, if data_valid=0 (or data_valid=1 with data_ready=1 in the same cycle): load data and set data_valid=1 on the next clock, go to S_IDLE.
  - Otherwise: overrun_error pulse, old data retained, go to S_IDLE.
- Latency: data_valid rises exactly 1 cycle after the committed mid-point of the last stop bit.
- Handshake: data_valid stays high until a cycle with data_ready=1; it clears on the next edge. data is stable while data_valid=1. data_ready while data_valid=0 has no effect. When DATA_BITS < 9, unused upper bits do not exist; the port is exactly DATA_BITS wide.
- Flags are mutually exclusive per frame and never overlap a reset cycle.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - state encodings S_WF_IDLE=0, S_IDLE=1, S_START=2, S_DATA=3, S_PARITY=4, S_STOP=5;
  - a function clog2 for sizing the timer and bit counter.
- Sub-module uart_rx_sampler (synchroniser plus 3-tap majority vote): takes clk, reset, sdin and the sample strobe; produces s and bit_val. The top-level FSM and holding register remain in uart_rx_param.

Test Plan:
All scenarios use CLKS_PER_BIT=16, except scenario 6.
1. 8N1, data_ready=1, send 0xA5 -> one data_valid pulse with data=0xA5, 1 cycle after the stop mid-sample; no flags.
2. DATA_BITS=7, PARITY=1 (even): send 0x35 with correct p=0, then 0x35 with p=1 -> first frame delivers data=0x35; second gives a parity_error pulse and data_valid stays 0.
3. 8N1: sdin low for 5 cycles, then high -> no state change beyond S_START, busy returns low, no outputs; a following 0x3C frame is received correctly.
4. 8N2: send 0x81 with the second stop bit 0, hold sdin low for 40 cycles, then idle and send 0x42 -> one framing_error pulse only; then data=0x42 valid.
5. data_ready=0: send 0x11 then 0x22 back-to-back -> data=0x11 valid held, overrun_error pulse at the end of the second frame; raise data_ready -> data_valid falls next cycle; data is never 0x22.
6. 9O1 with CLKS_PER_BIT=20: send 0x1FF, asserting reset for 1 cycle at data bit 4 -> all outputs 0, no flags; a subsequent 0x155 frame is received with data=0x155.
